// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
//   md op encodings (3 bits) and FSM state encodings.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_arith.sv
// Combinational datapath for MULT/MULTU/DIV/DIVU.
//   i_op        op code (MD_*)
//   i_a, i_b    rs / rt operands
//   o_hi, o_lo  64-bit result split into HI/LO
//   o_ok        0 when the result must not be committed (divide by zero)
module muldiv_ctrl_arith
  import muldiv_ctrl_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_ok
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_b_zero;
  logic        w_ovf;
  logic [31:0] w_sdiv;
  logic [31:0] w_udiv;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  assign w_b_zero = (i_b == 32'd0);
  assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // Dividing by 1 in the overflow case yields exactly quotient=a, remainder=0.
  // Divide-by-zero uses 1 too, so the divider never sees 0; result is discarded.
  assign w_sdiv = (w_b_zero || w_ovf) ? 32'd1 : i_b;
  assign w_udiv = w_b_zero ? 32'd1 : i_b;

  assign w_sq = $signed(i_a) / $signed(w_sdiv);
  assign w_sr = $signed(i_a) % $signed(w_sdiv);
  assign w_uq = i_a / w_udiv;
  assign w_ur = i_a % w_udiv;

  always_comb begin
    o_hi = 32'd0;
    o_lo = 32'd0;
    o_ok = 1'b1;
    case (i_op)
      MD_MULT:  {o_hi, o_lo} = w_prod_s;
      MD_MULTU: {o_hi, o_lo} = w_prod_u;
      MD_DIV: begin
        o_hi = w_sr;
        o_lo = w_sq;
        o_ok = !w_b_zero;
      end
      MD_DIVU: begin
        o_hi = w_ur;
        o_lo = w_uq;
        o_ok = !w_b_zero;
      end
      default: o_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers (E stage).
//   i_clk, i_reset  clock, synchronous active-low reset
//   i_start, i_op   E-stage md instruction valid / op code
//   i_a, i_b        forwarded rs / rt operands
//   i_flush         exception/eret in M; kills start and any in-flight op
//   o_busy          to D-stage stall logic (combinational)
//   o_hi, o_lo      HI / LO registers
//
//   state | meaning
//   IDLE  | no op in flight; accepts mul/div/mthi/mtlo
//   RUN   | result held in pend regs, counting down to commit
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_flush,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  // The start cycle is the first busy cycle, so RUN lasts N-1 cycles and
  // commits on the edge ending its cnt==0 cycle.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi_pend;
  logic [31:0]      r_lo_pend;
  logic             r_pend_ok;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_ok;
  logic        w_go;
  logic        w_is_md;
  logic        w_single;

  muldiv_ctrl_arith u_arith (
    .i_op (i_op),
    .i_a  (i_a),
    .i_b  (i_b),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo),
    .o_ok (w_res_ok)
  );

  assign w_go     = i_start && !i_flush;
  assign w_is_md  = is_muldiv(i_op);
  assign w_single = is_div(i_op) ? (DIV_CYCLES <= 1) : (MUL_CYCLES <= 1);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_hi_pend <= 32'd0;
      r_lo_pend <= 32'd0;
      r_pend_ok <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            if (w_is_md) begin
              if (w_single) begin
                if (w_res_ok) begin
                  r_hi <= w_res_hi;
                  r_lo <= w_res_lo;
                end
              end else begin
                r_hi_pend <= w_res_hi;
                r_lo_pend <= w_res_lo;
                r_pend_ok <= w_res_ok;
                r_cnt     <= is_div(i_op) ? DIV_LOAD : MUL_LOAD;
                r_state   <= ST_RUN;
              end
            end else if (i_op == MD_MTHI) begin
              r_hi <= i_a;
            end else if (i_op == MD_MTLO) begin
              r_lo <= i_a;
            end
          end
        end
        ST_RUN: begin
          if (i_flush) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend_ok <= 1'b0;
          end else if (r_cnt == '0) begin
            if (r_pend_ok) begin
              r_hi <= r_hi_pend;
              r_lo <= r_lo_pend;
            end
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall unit must hold md instrs in D while RUN; a start here is lost.
  always @(posedge i_clk) begin
    if (i_reset && (r_state == ST_RUN)) begin
      assert (!(i_start && !i_flush));
    end
  end

  assign o_busy = (w_go && w_is_md) || (r_state == ST_RUN);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
